// File: rtl/two_bit_mult.sv
`default_nettype none
// ============================================================================
// Module      : two_bit_mult
// Description : Two-stage pipelined unsigned W x W multiplier built from a
//               ripple-carry half/full-adder array over the partial products.
// Revision    : 1.0 - initial release
// ============================================================================
module two_bit_mult #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in1,
    input  logic [W-1:0]   in2,
    output logic [2*W-1:0] outv,
    output logic           out_valid
);

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [1:0]     r_valid_sr;
    logic [2*W-1:0] w_prod;

    logic [W:0]     w_acc;
    logic [W-1:0]   w_x;
    logic [W-1:0]   w_pp;
    logic           w_c;

    // Each cell returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_valid_sr <= '0;
            outv       <= '0;
        end else begin
            r_a        <= in1;
            r_b        <= in2;
            r_valid_sr <= {r_valid_sr[0], 1'b1};
            outv       <= w_prod;
        end
    end

    // Array: each row adds the next partial-product row to the upper bits of
    // the running sum; the LSB of every row retires one product bit.
    always_comb begin
        w_prod    = '0;
        w_pp      = '0;
        w_x       = '0;
        w_c       = 1'b0;
        w_acc     = {1'b0, r_a & {W{r_b[0]}}};
        w_prod[0] = w_acc[0];
        for (int i = 1; i < W; i++) begin
            w_pp = r_a & {W{r_b[i]}};
            w_x  = w_acc[W:1];
            w_c  = 1'b0;
            for (int j = 0; j < W; j++) begin
                if (j == 0)
                    {w_c, w_acc[j]} = half_add(w_x[j], w_pp[j]);
                else
                    {w_c, w_acc[j]} = full_add(w_x[j], w_pp[j], w_c);
            end
            w_acc[W]  = w_c;
            w_prod[i] = w_acc[0];
        end
        w_prod[2*W-1:W] = w_acc[W:1];
    end

    assign out_valid = r_valid_sr[1];

endmodule
`default_nettype wire

// File: tb/tb_two_bit_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_bit_mult
// Description : Scoreboard bench for two_bit_mult at W=2 and W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_two_bit_mult;

    logic       clk;
    logic       rst_n;
    logic [1:0] in1;
    logic [1:0] in2;
    logic [3:0] outv;
    logic       out_valid;
    logic [3:0] in1w;
    logic [3:0] in2w;
    logic [7:0] outvw;
    logic       out_validw;

    logic [3:0] q2[$];
    logic [7:0] q4[$];
    int         n_cmp;
    int         n_bad;
    logic       stim_done;

    // Hand-computed products indexed by {in2, in1}.
    logic [3:0] c_tbl [16] = '{4'd0, 4'd0, 4'd0, 4'd0,
                               4'd0, 4'd1, 4'd2, 4'd3,
                               4'd0, 4'd2, 4'd4, 4'd6,
                               4'd0, 4'd3, 4'd6, 4'd9};

    two_bit_mult #(.W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
        .outv(outv), .out_valid(out_valid)
    );

    two_bit_mult #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in1(in1w), .in2(in2w),
        .outv(outvw), .out_valid(out_validw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply operands at the current negedge, record expectations, advance one cycle.
    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [3:0] e2,
                        input logic [3:0] a4, input logic [3:0] b4, input logic [7:0] e4);
        in1  = a;
        in2  = b;
        in1w = a4;
        in2w = b4;
        q2.push_back(e2);
        q4.push_back(e4);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q2.size() != 0) chk("w2_product", 32'(outv), 32'(q2.pop_front()));
            else if (!stim_done) chk("w2_unexpected_output", 32'(1), 32'(0));
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_validw) begin
            if (q4.size() != 0) chk("w4_product", 32'(outvw), 32'(q4.pop_front()));
            else if (!stim_done) chk("w4_unexpected_output", 32'(1), 32'(0));
        end
    end

    initial begin
        logic [7:0] k;
        n_cmp     = 0;
        n_bad     = 0;
        stim_done = 1'b0;
        rst_n     = 1'b1;
        in1 = '0; in2 = '0; in1w = '0; in2w = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outv", 32'(outv), 32'(0));
        chk("reset_valid", 32'(out_valid), 32'(0));
        chk("reset_outv_w4", 32'(outvw), 32'(0));

        // Latency from reset release: 3*2 must appear only after E1.
        rst_n = 1'b1;
        step(2'd3, 2'd2, 4'd6, 4'd3, 4'd2, 8'd6);
        chk("lat_outv_before_E1", 32'(outv), 32'(0));
        chk("lat_valid_before_E1", 32'(out_valid), 32'(0));
        step(2'd3, 2'd2, 4'd6, 4'd3, 4'd2, 8'd6);
        chk("lat_valid_after_E1", 32'(out_valid), 32'(1));
        chk("lat_outv_after_E1", 32'(outv), 32'(6));

        // Back-to-back and spot checks.
        step(2'd1, 2'd1, 4'd1, 4'd1, 4'd1, 8'd1);
        step(2'd3, 2'd3, 4'd9, 4'd3, 4'd3, 8'd9);
        step(2'd2, 2'd1, 4'd2, 4'd2, 4'd1, 8'd2);
        step(2'd0, 2'd3, 4'd0, 4'd0, 4'd15, 8'd0);
        step(2'd1, 2'd3, 4'd3, 4'd15, 4'd15, 8'hE1);
        step(2'd2, 2'd2, 4'd4, 4'd9, 4'd7, 8'd63);
        step(2'd2, 2'd3, 4'd6, 4'd12, 4'd10, 8'd120);

        // Mid-stream reset while 3*3 is streaming.
        repeat (3) step(2'd3, 2'd3, 4'd9, 4'd3, 4'd3, 8'd9);
        chk("pre_reset_outv", 32'(outv), 32'(9));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outv", 32'(outv), 32'(0));
        chk("async_reset_valid", 32'(out_valid), 32'(0));
        chk("async_reset_outv_w4", 32'(outvw), 32'(0));
        q2.delete();
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'd3, 2'd3, 4'd9, 4'd3, 4'd3, 8'd9);
        chk("rel_valid_before_E1", 32'(out_valid), 32'(0));
        step(2'd3, 2'd3, 4'd9, 4'd3, 4'd3, 8'd9);
        chk("rel_outv_after_E1", 32'(outv), 32'(9));

        // Idle stability.
        for (int i = 0; i < 10; i++) begin
            step(2'd2, 2'd3, 4'd6, 4'd5, 4'd5, 8'd25);
            chk("idle_valid", 32'(out_valid), 32'(1));
        end

        // Exhaustive sweeps: W=2 pairs repeat 16 times inside the W=4 sweep.
        for (int i = 0; i < 256; i++) begin
            k = 8'(i);
            step(k[1:0], k[3:2], c_tbl[k[3:0]], k[3:0], k[7:4],
                 8'(32'(k[3:0]) * 32'(k[7:4])));
        end

        stim_done = 1'b1;
        for (int i = 0; i < 6 && (q2.size() != 0 || q4.size() != 0); i++)
            @(negedge clk);
        chk("drain_w2", 32'(q2.size()), 32'(0));
        chk("drain_w4", 32'(q4.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
